// File: rtl/puf_ecc_pkg.sv
// Shared types and constants for the PUF ECC engine scheduler: engine
// instruction codes, scheduler state encodings and requester op codes.
package puf_ecc_pkg;

  typedef enum logic [1:0] {
    PCM_IDLE      = 2'b00,
    PCM_PROVISION = 2'b01,
    PCM_CORRECT   = 2'b10
  } pcm_instr_t;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t ST_ARB     = 3'd0;
  localparam sched_state_t ST_CMD     = 3'd1;
  localparam sched_state_t ST_WAIT    = 3'd2;
  localparam sched_state_t ST_RELEASE = 3'd3;
  localparam sched_state_t ST_DRAIN   = 3'd4;
  localparam sched_state_t ST_RESP    = 3'd5;

  localparam logic OP_PROVISION = 1'b0;
  localparam logic OP_CORRECT   = 1'b1;

  function automatic pcm_instr_t op_to_instr(input logic op);
    return (op == OP_CORRECT) ? PCM_CORRECT : PCM_PROVISION;
  endfunction

endpackage

// File: rtl/puf_ecc_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// (last_grant + 1) mod N while advance is high.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic          advance,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic          found;
  int            cand;
  logic [IW-1:0] cand_idx;

  // Rotating priority scan starting one past the previous winner
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= N) begin
        cand = cand - N;
      end else begin
        cand = cand;
      end
      cand_idx = IW'(cand);
      if (advance && !found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/puf_ecc_scheduler.sv
// Shares one SECDED engine between NUM_REQ requesters. Optional per-phase
// timeout is enabled by defining PUF_ECC_TIMEOUT_EN.
module puf_ecc_scheduler
  import puf_ecc_pkg::*;
#(
  parameter int puf_sig_length = 256,
  parameter int ipid_N         = 16,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_op,
  input  logic [NUM_REQ*$clog2(ipid_N)-1:0] req_ipid,
  input  logic [NUM_REQ*puf_sig_length-1:0] req_sig,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                resp_valid,
  output logic [puf_sig_length-1:0]         resp_sig,
  output logic                              resp_err,
  output logic [1:0]                        pcm_instruction,
  output logic [puf_sig_length-1:0]         pcm_puf_in,
  output logic                              pcm_puf_in_valid,
  output logic [$clog2(ipid_N)-1:0]         pcm_ipid_number,
  input  logic [puf_sig_length-1:0]         pcm_puf_out,
  input  logic                              pcm_puf_out_valid,
  input  logic                              pcm_S_c
);

  localparam int IPW = $clog2(ipid_N);
  localparam int IW  = $clog2(NUM_REQ);

  sched_state_t              state, state_nxt;
  logic [IW-1:0]             last_grant, grant_idx;
  logic [NUM_REQ-1:0]        grant;
  logic                      op_q;
  logic [IPW-1:0]            ipid_q;
  logic [puf_sig_length-1:0] sig_q, result_q;
  logic                      done, drained, wait_tmo, drain_tmo;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req        (req_valid),
    .advance    ((state == ST_ARB) && !rst),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = grant;
  assign done      = (op_q == OP_CORRECT) ? pcm_puf_out_valid : pcm_S_c;
  assign drained   = !pcm_S_c && !pcm_puf_out_valid;

  // The latched signature stays on pcm_puf_in through RELEASE so the engine's
  // parity rewrite on leaving provision sees the same data.
  assign pcm_instruction  = ((state == ST_CMD) || (state == ST_WAIT)) ? op_to_instr(op_q) : PCM_IDLE;
  assign pcm_puf_in_valid = (state == ST_CMD) || (state == ST_WAIT) || (state == ST_RELEASE);
  assign pcm_puf_in       = sig_q;
  assign pcm_ipid_number  = ipid_q;

`ifdef PUF_ECC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit, err_q, resp_err_q;

  assign tmo_hit   = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign wait_tmo  = (state == ST_WAIT) && !done && tmo_hit;
  assign drain_tmo = (state == ST_DRAIN) && !drained && tmo_hit;
  assign resp_err  = resp_err_q;

  // Phase timer plus sticky error flag for the current transaction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt    <= '0;
      err_q      <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      if ((state == ST_CMD) || (state == ST_RELEASE)) begin
        tmo_cnt <= '0;
      end else if ((state == ST_WAIT) || (state == ST_DRAIN)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (state == ST_ARB) begin
        err_q <= 1'b0;
      end else if (wait_tmo || drain_tmo) begin
        err_q <= 1'b1;
      end
      if ((state == ST_DRAIN) && (state_nxt == ST_RESP)) begin
        resp_err_q <= err_q | drain_tmo;
      end
    end
  end
`else
  assign wait_tmo  = 1'b0;
  assign drain_tmo = 1'b0;
  assign resp_err  = 1'b0;
`endif

  // Transaction sequencing
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB:     if (|grant) state_nxt = ST_CMD; else state_nxt = ST_ARB;
      ST_CMD:     state_nxt = ST_WAIT;
      ST_WAIT:    if (done || wait_tmo) state_nxt = ST_RELEASE; else state_nxt = ST_WAIT;
      ST_RELEASE: state_nxt = ST_DRAIN;
      ST_DRAIN:   if (drained || drain_tmo) state_nxt = ST_RESP; else state_nxt = ST_DRAIN;
      ST_RESP:    state_nxt = ST_ARB;
      default:    state_nxt = ST_ARB;
    endcase
  end

  // Request latches, engine result capture and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_ARB;
      last_grant <= IW'(NUM_REQ - 1);
      op_q       <= OP_PROVISION;
      ipid_q     <= '0;
      sig_q      <= '0;
      result_q   <= '0;
      resp_valid <= '0;
      resp_sig   <= '0;
    end else begin
      state      <= state_nxt;
      resp_valid <= '0;
      if ((state == ST_ARB) && (|grant)) begin
        last_grant <= grant_idx;
        op_q       <= req_op[grant_idx];
        ipid_q     <= req_ipid[grant_idx*IPW +: IPW];
        sig_q      <= req_sig[grant_idx*puf_sig_length +: puf_sig_length];
        result_q   <= '0;
      end else if ((state == ST_WAIT) && done && (op_q == OP_CORRECT)) begin
        result_q <= pcm_puf_out;
      end
      if ((state == ST_DRAIN) && (state_nxt == ST_RESP)) begin
        resp_valid <= {{(NUM_REQ-1){1'b0}}, 1'b1} << last_grant;
        resp_sig   <= (op_q == OP_CORRECT) ? result_q : '0;
      end
    end
  end

endmodule

// File: tb/tb_puf_ecc_scheduler.sv
// Randomized bench for puf_ecc_scheduler with a behavioural engine stub and a
// transaction-level reference model of arbitration, latency and results.
module tb_puf_ecc_scheduler;

  localparam int L   = 256;
  localparam int IPN = 16;
  localparam int NR  = 4;
  localparam int TO  = 8;
  localparam int IPW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_op, req_ready, resp_valid;
  logic [NR*IPW-1:0] req_ipid;
  logic [NR*L-1:0]   req_sig;
  logic [L-1:0]      resp_sig, pcm_puf_in, pcm_puf_out;
  logic              resp_err, pcm_puf_in_valid, pcm_puf_out_valid, pcm_S_c;
  logic [1:0]        pcm_instruction;
  logic [IPW-1:0]    pcm_ipid_number;

  always #5 clk = ~clk;

  puf_ecc_scheduler #(.puf_sig_length(L), .ipid_N(IPN), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_ipid(req_ipid),
    .req_sig(req_sig), .req_ready(req_ready), .resp_valid(resp_valid), .resp_sig(resp_sig),
    .resp_err(resp_err), .pcm_instruction(pcm_instruction), .pcm_puf_in(pcm_puf_in),
    .pcm_puf_in_valid(pcm_puf_in_valid), .pcm_ipid_number(pcm_ipid_number),
    .pcm_puf_out(pcm_puf_out), .pcm_puf_out_valid(pcm_puf_out_valid), .pcm_S_c(pcm_S_c)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_value(input string tag, input logic [L-1:0] obs, input logic [L-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Idealised SECDED: at most one flipped bit per 16-bit lane is repaired
  function automatic logic [L-1:0] ecc_fix(input logic [L-1:0] raw, input logic [L-1:0] golden);
    logic [L-1:0] d;
    d = raw ^ golden;
    for (int k = 0; k < L/16; k++)
      if ($countones(d[16*k +: 16]) > 1) return raw;
    return golden;
  endfunction

  // Engine stub: answers two cycles after the command, releases on IDLE+valid
  logic [L-1:0] eng_store [IPN];
  int           eng_cnt;
  bit           eng_rel;
  bit           eng_mute = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pcm_S_c <= 1'b0; pcm_puf_out_valid <= 1'b0; pcm_puf_out <= '0;
      eng_cnt <= 0; eng_rel <= 1'b0;
      for (int i = 0; i < IPN; i++) eng_store[i] <= '0;
    end else if (pcm_puf_in_valid && pcm_instruction != 2'b00) begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == 1 && !eng_mute) begin
        if (pcm_instruction == 2'b01) begin
          pcm_S_c <= 1'b1;
          eng_store[pcm_ipid_number] <= pcm_puf_in;
        end else begin
          pcm_puf_out_valid <= 1'b1;
          pcm_puf_out <= ecc_fix(pcm_puf_in, eng_store[pcm_ipid_number]);
        end
      end
    end else if (pcm_puf_in_valid) begin
      eng_cnt <= 0; pcm_S_c <= 1'b0; eng_rel <= 1'b1;
    end else if (eng_rel) begin
      pcm_puf_out_valid <= 1'b0; eng_rel <= 1'b0;
    end
  end

  // Reference model state
  typedef struct { bit v; bit op; logic [IPW-1:0] ipid; logic [L-1:0] sig; } req_t;
  req_t           pend [NR];
  logic [L-1:0]   mdl_store [IPN];
  int             cyc = 0, t0 = 0, g_cur = 0, rr = NR - 1;
  bit             busy = 1'b0, cur_op, cur_mute;
  logic [IPW-1:0] cur_ipid;
  logic [L-1:0]   cur_sig, exp_sig;

  function automatic logic [L-1:0] rand_sig();
    logic [L-1:0] s;
    for (int k = 0; k < L/32; k++) s[32*k +: 32] = $urandom();
    return s;
  endfunction

  function automatic logic [L-1:0] noisy(input logic [L-1:0] s, input bit two);
    logic [L-1:0] r;
    r = s;
    for (int k = 0; k < L/16; k++) r[16*k + $urandom_range(15)] ^= 1'b1;
    if (two) r[$urandom_range(15)] ^= 1'b1;
    return r;
  endfunction

  function automatic bit any_pend();
    for (int i = 0; i < NR; i++) if (pend[i].v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = pend[i].v;
      req_op[i]    = pend[i].op;
      req_ipid[i*IPW +: IPW] = pend[i].ipid;
      req_sig[i*L +: L]      = pend[i].sig;
    end
  endtask

  task automatic set_req(input int i, input bit op, input logic [IPW-1:0] ipid, input logic [L-1:0] sig);
    pend[i].v = 1'b1; pend[i].op = op; pend[i].ipid = ipid; pend[i].sig = sig;
  endtask

  // One clock: drive after the rising edge, check at the falling edge
  task automatic step();
    int g, c, rel, rsp;
    @(posedge clk); #1; drive();
    @(negedge clk);
    if (!busy) begin
      g = -1;
      for (int k = 1; k <= NR; k++) if (g < 0 && pend[(rr + k) % NR].v) g = (rr + k) % NR;
      check_value("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
      check_value("resp_valid_idle", resp_valid, 0);
      if (g >= 0) begin
        busy = 1'b1; t0 = cyc; g_cur = g; rr = g;
        cur_op = pend[g].op; cur_ipid = pend[g].ipid; cur_sig = pend[g].sig; cur_mute = eng_mute;
        exp_sig = (cur_mute || !cur_op) ? '0 : ecc_fix(cur_sig, mdl_store[cur_ipid]);
        pend[g].v = 1'b0;
      end
    end else begin
      c   = cyc - t0;
      rel = cur_mute ? 2 + TO : 4;
      rsp = cur_mute ? rel + 2 : (cur_op ? 7 : 6);
      check_value("req_ready_busy", req_ready, 0);
      if (c == 1) begin
        check_value("instr_cmd", pcm_instruction, cur_op ? 2 : 1);
        check_value("valid_cmd", pcm_puf_in_valid, 1);
        check_value("ipid_cmd", pcm_ipid_number, cur_ipid);
        check_value("sig_cmd", pcm_puf_in, cur_sig);
      end
      if (c == rel) begin
        check_value("instr_release", pcm_instruction, 0);
        check_value("valid_release", pcm_puf_in_valid, 1);
      end
      if (c == rel + 1) check_value("valid_drain", pcm_puf_in_valid, 0);
      if (c == rsp) begin
        check_value("resp_valid", resp_valid, 1 << g_cur);
        check_value("resp_sig", resp_sig, exp_sig);
        check_value("resp_err", resp_err, cur_mute);
        if (!cur_op && !cur_mute) mdl_store[cur_ipid] = cur_sig;
        busy = 1'b0;
      end else begin
        check_value("resp_valid_quiet", resp_valid, 0);
      end
    end
    cyc++;
  endtask

  task automatic reset_check(input string tag);
    rst = 1'b1;
    req_valid = '1;
    #1;
    check_value({tag, "_ready"}, req_ready, 0);
    check_value({tag, "_resp_valid"}, resp_valid, 0);
    check_value({tag, "_instr"}, pcm_instruction, 0);
    check_value({tag, "_in_valid"}, pcm_puf_in_valid, 0);
    check_value({tag, "_puf_in"}, pcm_puf_in, 0);
    check_value({tag, "_ipid"}, pcm_ipid_number, 0);
    check_value({tag, "_resp_sig"}, resp_sig, 0);
    check_value({tag, "_resp_err"}, resp_err, 0);
    for (int i = 0; i < NR; i++) pend[i].v = 1'b0;
    for (int i = 0; i < IPN; i++) mdl_store[i] = '0;
    busy = 1'b0; rr = NR - 1;
    @(posedge clk); #1;
    drive();
    rst = 1'b0;
  endtask

  logic [L-1:0] s_a5, raw;
  bit reissued;

  initial begin
    for (int i = 0; i < NR; i++) begin pend[i].v = 1'b0; pend[i].op = 1'b0; pend[i].ipid = '0; pend[i].sig = '0; end
    drive();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    reset_check("reset");

    // Provision from requester 1, then a noisy correct of the same slot
    s_a5 = {16{16'hA5A5}};
    set_req(1, 1'b0, 4'd3, s_a5);
    repeat (10) step();
    raw = s_a5;
    for (int k = 0; k < L/16; k++) raw[16*k + (k % 16)] ^= 1'b1;
    set_req(2, 1'b1, 4'd3, raw);
    repeat (10) step();
    check_value("tp2_sig", resp_sig, s_a5);
    check_value("tp2_err", resp_err, 0);

    // Reset while the engine is being waited on
    set_req(3, 1'b0, 4'd5, rand_sig());
    step(); step();
    @(posedge clk); #1;
    reset_check("mid_reset");

    // All four held together; requester 0 asks again straight after its grant
    for (int i = 0; i < NR; i++) set_req(i, 1'(i % 2), IPW'(i), rand_sig());
    reissued = 1'b0;
    repeat (45) begin
      step();
      if (!pend[0].v && !reissued) begin set_req(0, 1'b0, 4'd7, rand_sig()); reissued = 1'b1; end
    end

`ifdef PUF_ECC_TIMEOUT_EN
    while (busy || any_pend()) step();
    eng_mute = 1'b1;
    set_req(1, 1'b0, 4'd2, rand_sig());
    repeat (14) step();
    eng_mute = 1'b0;
`endif

    // Randomised traffic with arrivals, withdrawals and noisy corrects
    repeat (3000) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i].v && $urandom_range(99) < 8) begin
          pend[i].v    = 1'b1;
          pend[i].op   = 1'($urandom_range(1));
          pend[i].ipid = IPW'($urandom_range(IPN - 1));
          pend[i].sig  = pend[i].op ? noisy(mdl_store[pend[i].ipid], $urandom_range(9) == 0) : rand_sig();
        end else if (pend[i].v && $urandom_range(99) < 2) begin
          pend[i].v = 1'b0;
        end
      end
      step();
    end
    for (int n = 0; n < 300 && (busy || any_pend()); n++) step();
    check_value("drain_done", busy || any_pend(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
